// File: rtl/forthsuper_pkg.sv
// Shared types and helpers for the number-conversion path of the outer interpreter.
// Build option FORTHSUPER_NUM_OVF_EN (see num_acc) does not change anything in here.
package forthsuper_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, CHK, FIN} num_sched_st;

  localparam logic [7:0] CH_MINUS  = 8'h2d;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [4:0] DIG_NA    = 5'b10000;

  // Letters share a low nibble layout: 'a'/'A' end in 1, so value = nibble + 9.
  function automatic logic [4:0] digit_val(input logic [7:0] ch);
    if (ch >= 8'h30 && ch <= 8'h39)
      return {1'b0, ch[3:0]};
    else if ((ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46))
      return {1'b0, ch[3:0]} + 5'd9;
    else
      return DIG_NA;
  endfunction

endpackage

// File: rtl/num_acc.sv
// Digit accumulator: acc <= acc*base + d. With FORTHSUPER_NUM_OVF_EN defined it also
// raises a sticky ovf when the true result leaves the signed range for the current sign.
module num_acc
  import forthsuper_pkg::*;
#(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           step,
  input  logic           hex,
  input  logic [3:0]     d,
`ifdef FORTHSUPER_NUM_OVF_EN
  input  logic           neg,
  output logic           ovf,
`endif
  output logic [DSZ-1:0] acc
);

`ifdef FORTHSUPER_NUM_OVF_EN
  localparam int WW = DSZ + 5;
  logic [WW-1:0] base, prod, limit;

  assign base  = hex ? WW'(16) : WW'(10);
  assign prod  = WW'(acc) * base + WW'(d);
  // A negative number may reach one step further than a positive one.
  assign limit = neg ? (WW'(1) << (DSZ-1)) : ((WW'(1) << (DSZ-1)) - WW'(1));

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (step) begin
      acc <= prod[DSZ-1:0];
      if (prod > limit) ovf <= 1'b1;
    end
  end
`else
  logic [DSZ-1:0] base, prod;

  assign base = hex ? DSZ'(16) : DSZ'(10);
  assign prod = acc * base + DSZ'(d);

  always_ff @(posedge clk) begin
    if (clr)       acc <= '0;
    else if (step) acc <= prod;
  end
`endif

endmodule

// File: rtl/num_sched.sv
// Round-robin scheduler for the shared string-to-integer path: fetches one character
// per two cycles, feeds num_acc, reports result/err on done. Honours FORTHSUPER_NUM_OVF_EN.
module num_sched
  import forthsuper_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ASZ  = 17,
  parameter int DSZ  = 32,
  parameter int LSZ  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*ASZ-1:0] addr_i,
  input  logic [NREQ*LSZ-1:0] len_i,
  input  logic [NREQ-1:0]     hex_i,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic                err,
  output logic [DSZ-1:0]      vo,
  output logic [ASZ-1:0]      mb_ai,
  output logic                mb_re,
  input  logic [7:0]          mb_vo
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  num_sched_st     st, st_n;
  logic [NREQ-1:0] gnt_q;
  logic [PW-1:0]   gidx, ptr, sel;
  logic            sel_vld, own;
  logic [ASZ-1:0]  addr_q;
  logic [LSZ-1:0]  len_q;
  logic            hex_q, neg_q, first_q, err_q, err_fin;
  logic [DSZ-1:0]  vo_q, acc, res;
  logic [4:0]      dv;
  logic            is_neg, is_pfx, is_dig, adv, last;
  logic            acc_clr, acc_step;

  logic [ASZ-1:0] addr_a [NREQ];
  logic [LSZ-1:0] len_a  [NREQ];

  for (genvar r = 0; r < NREQ; r++) begin : g_unpk
    assign addr_a[r] = addr_i[r*ASZ +: ASZ];
    assign len_a[r]  = len_i[r*LSZ +: LSZ];
  end

  // Scan from ptr upward; descending loop so the nearest requester wins.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      int k;
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req[PW'(k)]) begin
        sel_vld = 1'b1;
        sel     = PW'(k);
      end
    end
  end

  assign own    = req[gidx];
  assign dv     = digit_val(mb_vo);
  assign is_neg = first_q && (mb_vo == CH_MINUS);
  assign is_pfx = first_q && (mb_vo == CH_DOLLAR);
  assign is_dig = dv < (hex_q ? 5'd16 : 5'd10);
  assign adv    = is_neg || is_pfx || is_dig;
  assign last   = (len_q == LSZ'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_n;
  end

  always_comb begin
    st_n     = st;
    acc_clr  = 1'b0;
    acc_step = 1'b0;
    case (st)
      IDLE:
        if (sel_vld) begin
          acc_clr = 1'b1;
          st_n    = (len_a[sel] == '0) ? FIN : FETCH;
        end
      FETCH: st_n = own ? CHK : IDLE;
      CHK:
        if (!own) st_n = IDLE;
        else begin
          acc_step = is_dig;
          st_n     = (!adv || last) ? FIN : FETCH;
        end
      FIN:     st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      gidx    <= '0;
      ptr     <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      hex_q   <= 1'b0;
      neg_q   <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      vo_q    <= '0;
    end else begin
      vo_q <= vo;
      case (st)
        IDLE:
          if (sel_vld) begin
            gnt_q   <= NREQ'(1) << sel;
            gidx    <= sel;
            ptr     <= (int'(sel) == NREQ-1) ? '0 : sel + PW'(1);
            addr_q  <= addr_a[sel];
            len_q   <= len_a[sel];
            hex_q   <= hex_i[sel];
            neg_q   <= 1'b0;
            first_q <= 1'b1;
            err_q   <= (len_a[sel] == '0);
          end
        FETCH: if (!own) gnt_q <= '0;
        CHK:
          if (!own) gnt_q <= '0;
          else begin
            if (adv) begin
              addr_q  <= addr_q + ASZ'(1);
              len_q   <= len_q - LSZ'(1);
              first_q <= 1'b0;
            end
            if (is_neg) neg_q <= 1'b1;
            if (is_pfx) hex_q <= 1'b1;
            // A lone sign or prefix ending the token is not a number either.
            if (!adv || ((is_neg || is_pfx) && last)) err_q <= 1'b1;
          end
        FIN:     gnt_q <= '0;
        default: gnt_q <= '0;
      endcase
    end
  end

`ifdef FORTHSUPER_NUM_OVF_EN
  logic ovf;
  num_acc #(.DSZ(DSZ)) u_acc (
    .clk(clk), .clr(acc_clr), .step(acc_step), .hex(hex_q), .d(dv[3:0]),
    .neg(neg_q), .ovf(ovf), .acc(acc)
  );
  assign err_fin = err_q | ovf;
`else
  num_acc #(.DSZ(DSZ)) u_acc (
    .clk(clk), .clr(acc_clr), .step(acc_step), .hex(hex_q), .d(dv[3:0]),
    .acc(acc)
  );
  assign err_fin = err_q;
`endif

  assign res   = neg_q ? -acc : acc;
  assign gnt   = gnt_q;
  assign done  = (st == FIN) ? gnt_q : '0;
  assign err   = (st == FIN) && err_fin;
  assign vo    = ((st == FIN) && !err_fin) ? res : vo_q;
  assign mb_re = (st == FETCH);
  assign mb_ai = mb_re ? addr_q : '0;

endmodule

// File: tb/tb_num_sched.sv
// Directed bench for num_sched: table of tokens with hand-computed results, then
// sequences for arbitration order, mid-token reset and owner abort.
module tb_num_sched;

  localparam int NREQ = 2, ASZ = 17, DSZ = 32, LSZ = 8;

  logic                clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0, hex_i = '0;
  logic [NREQ*ASZ-1:0] addr_i = '0;
  logic [NREQ*LSZ-1:0] len_i = '0;
  logic [NREQ-1:0]     gnt, done;
  logic                err, mb_re;
  logic [DSZ-1:0]      vo;
  logic [ASZ-1:0]      mb_ai;
  logic [7:0]          mb_vo = 8'h00;

  bit [7:0] mem [0:(1<<ASZ)-1];

  num_sched #(.NREQ(NREQ), .ASZ(ASZ), .DSZ(DSZ), .LSZ(LSZ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_i(addr_i), .len_i(len_i),
    .hex_i(hex_i), .gnt(gnt), .done(done), .err(err), .vo(vo),
    .mb_ai(mb_ai), .mb_re(mb_re), .mb_vo(mb_vo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mb_re) mb_vo <= mem[mb_ai];

  int errors = 0, checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic put_str(input int a, input string s);
    for (int i = 0; i < s.len(); i++) mem[a+i] = s[i];
  endtask

  task automatic set_tok(input int rq, input int a, input int l, input bit hx);
    addr_i[rq*ASZ +: ASZ] = ASZ'(a);
    len_i[rq*LSZ +: LSZ]  = LSZ'(l);
    hex_i[rq]             = hx;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input logic [NREQ-1:0] exp, input string nm);
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (done != '0) seen = 1;
    end
    check({nm, " done"}, done, exp);
  endtask

  task automatic quiet(input int n, input string nm);
    int cnt = 0;
    repeat (n) begin
      tick();
      if (done != '0) cnt++;
    end
    check({nm, " no done"}, cnt, 0);
  endtask

  typedef struct {
    int          rq;
    int          a;
    string       s;
    int          l;
    bit          hx;
    logic [31:0] vo;
    bit          er;
    int          cyc;
    string       nm;
  } vec_t;

  // Cycle 1 is the first cycle req is high in IDLE; done shows in cycle 2N+2.
  task automatic run_tok(input vec_t v);
    int cyc = 1;
    bit seen = 0;
    put_str(v.a, v.s);
    set_tok(v.rq, v.a, v.l, v.hx);
    tick();
    req[v.rq] = 1'b1;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      cyc++;
      if (done != '0) seen = 1;
    end
    check({v.nm, " seen"}, seen, 1);
    check({v.nm, " cycle"}, cyc, v.cyc);
    check({v.nm, " done"}, done, NREQ'(1) << v.rq);
    check({v.nm, " gnt"}, gnt, NREQ'(1) << v.rq);
    check({v.nm, " vo"}, vo, v.vo);
    check({v.nm, " err"}, err, v.er);
    req[v.rq] = 1'b0;
    tick();
    check({v.nm, " done drop"}, done, 0);
    check({v.nm, " gnt drop"}, gnt, 0);
    check({v.nm, " vo hold"}, vo, v.vo);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{0, 'h00100, "123",         3,  0, 32'd123,        0, 8,  "dec123"});
    tbl.push_back('{1, 'h10200, "-1F",         3,  1, 32'hFFFFFFE1,   0, 8,  "hexneg"});
    tbl.push_back('{0, 'h00300, "$ff",         3,  0, 32'd255,        0, 8,  "prefix"});
    tbl.push_back('{0, 'h00400, "12x4",        4,  0, 32'd255,        1, 8,  "badchar"});
    tbl.push_back('{0, 'h00500, "-",           1,  0, 32'd255,        1, 4,  "lonesign"});
    tbl.push_back('{1, 'h00600, "",            0,  0, 32'd255,        1, 2,  "len0"});
    tbl.push_back('{1, 'h00700, "7FFFFFFF",    8,  1, 32'h7FFFFFFF,   0, 18, "maxpos"});
    tbl.push_back('{0, 'h00800, "9a",          2,  0, 32'h7FFFFFFF,   1, 6,  "basechk"});
    tbl.push_back('{0, 'h00900, "-$5",         3,  0, 32'h7FFFFFFF,   1, 6,  "late_pfx"});
    tbl.push_back('{1, 'h00A00, "-0",          2,  0, 32'd0,          0, 6,  "negzero"});
    tbl.push_back('{0, 'h00B00, "-2147483648", 11, 0, 32'h80000000,   0, 24, "minneg"});
`ifdef FORTHSUPER_NUM_OVF_EN
    tbl.push_back('{0, 'h00C00, "4294967296",  10, 0, 32'h80000000,   1, 22, "ovf2p32"});
    tbl.push_back('{1, 'h00D00, "2147483648",  10, 0, 32'h80000000,   1, 22, "ovf2p31"});
`else
    tbl.push_back('{0, 'h00C00, "4294967296",  10, 0, 32'd0,          0, 22, "wrap2p32"});
    tbl.push_back('{1, 'h00D00, "2147483648",  10, 0, 32'h80000000,   0, 22, "wrap2p31"});
`endif
    tbl.push_back('{0, 'h00E00, "$",           1,  1, 32'h80000000,   1, 4,  "lonepfx"});
    tbl.push_back('{0, 'h00F00, "123",         2,  0, 32'd12,         0, 6,  "shortlen"});

    // Reset state
    repeat (2) tick();
    check("rst gnt", gnt, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst vo", vo, 0);
    check("rst mb_re", mb_re, 0);
    check("rst mb_ai", mb_ai, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_tok(tbl[i]);

    // Reset in the middle of a token
    set_tok(0, 'h00100, 3, 0);
    req[0] = 1'b1;
    repeat (4) tick();
    check("midrst busy", gnt, 2'b01);
    rst_n = 1'b0;
    req   = '0;
    tick();
    check("midrst gnt", gnt, 0);
    check("midrst done", done, 0);
    check("midrst vo", vo, 0);
    check("midrst mb_re", mb_re, 0);
    rst_n = 1'b1;
    quiet(12, "midrst");

    // Simultaneous requests after reset: 0 then 1, and the next pair in the same order
    set_tok(0, 'h00100, 3, 0);
    set_tok(1, 'h10200, 3, 1);
    req = 2'b11;
    tick();
    check("arb first gnt", gnt, 2'b01);
    repeat (3) tick();
    check("arb holdoff", gnt, 2'b01);
    wait_done(2'b01, "arb req0");
    check("arb vo0", vo, 32'd123);
    req[0] = 1'b0;
    tick();
    check("arb gap gnt", gnt, 0);
    tick();
    check("arb second gnt", gnt, 2'b10);
    wait_done(2'b10, "arb req1");
    check("arb vo1", vo, 32'hFFFFFFE1);
    req[1] = 1'b0;
    tick();
    req = 2'b11;
    tick();
    check("arb pair2 gnt", gnt, 2'b01);
    wait_done(2'b01, "arb pair2");
    req = '0;
    tick();
    check("arb idle gnt", gnt, 0);

    // Owner drops req mid-token: abort, no done; pointer has moved past requester 0
    req[0] = 1'b1;
    repeat (3) tick();
    check("abort busy", gnt, 2'b01);
    req[0] = 1'b0;
    tick();
    check("abort gnt", gnt, 0);
    quiet(10, "abort");
    check("abort vo hold", vo, 32'd123);
    req = 2'b11;
    tick();
    check("abort next gnt", gnt, 2'b10);
    wait_done(2'b10, "abort next");
    check("abort next vo", vo, 32'hFFFFFFE1);
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
